mem_stage: RTL

EX/MEM pipeline register plus MEM stage of the pipelined CPU. It consumes the execute stage's result bundle (ALU result, store data, destination register, control) and performs the data-memory access over a ready-handshake bus. It stalls the upstream pipeline while that access is outstanding. It then drives the MEM/WB register, and returns RegWrite_mem/RegWriteAddr_mem/ALUResult_mem and RegWrite_wb/RegWriteAddr_wb/RegWriteData to the execute stage's forwarding logic.

---
 rtl/mem_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// EX/MEM pipeline register and MEM stage: data-memory access over a ready
// handshake, stall generation, bounded wait with abort, and the MEM/WB register.
// Results reach MEM/WB one cycle after leaving EX/MEM. Each wait cycle adds one stall.
module mem_stage #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemWriteData,
  input  logic [4:0]  RegWriteAddr,
  input  logic [31:0] PC_4_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic [1:0]  MemToReg_ex,
  input  logic        Flush_ex,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] ALUResult_mem,
  output logic        RegWrite_mem,
  output logic [4:0]  RegWriteAddr_mem,
  output logic        RegWrite_wb,
  output logic [4:0]  RegWriteAddr_wb,
  output logic [31:0] RegWriteData,
  output logic        MemErr
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // EX/MEM register fields
  logic [31:0] alu_q, wdata_q, pc4_q;
  logic [4:0]  rd_q;
  logic        rw_q, mrd_q, mwr_q;
  logic [1:0]  m2r_q;

  // FSM, timeout counter and sticky error
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        abort;
  logic        mem_op;

  // MEM/WB register fields
  logic        rw_wb_q;
  logic [4:0]  rd_wb_q;
  logic [31:0] wb_data_q;
  logic [31:0] wb_data_d;

  assign mem_op = mrd_q | mwr_q;

  // EX/MEM register: load on non-stall edges, bubble on flush, hold on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q <= '0; wdata_q <= '0; pc4_q <= '0; rd_q <= '0;
      rw_q <= 1'b0; mrd_q <= 1'b0; mwr_q <= 1'b0; m2r_q <= '0;
    end else if (!Stall) begin
      if (Flush_ex) begin
        alu_q <= '0; wdata_q <= '0; pc4_q <= '0; rd_q <= '0;
        rw_q <= 1'b0; mrd_q <= 1'b0; mwr_q <= 1'b0; m2r_q <= '0;
      end else begin
        alu_q   <= ALUResult;
        wdata_q <= MemWriteData;
        pc4_q   <= PC_4_ex;
        rd_q    <= RegWriteAddr;
        rw_q    <= RegWrite_ex;
        mrd_q   <= MemRead_ex;
        mwr_q   <= MemWrite_ex;
        m2r_q   <= MemToReg_ex;
      end
    end
  end

  // FSM state register with counter and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // FSM next state: enter WAIT on an unfinished access, leave on ready or timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op && !mem_ready) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: abort in the last wait cycle, stall while access is pending
  always_comb begin
    abort   = (state_q == S_WAIT) && !mem_ready && (cnt_q == CNT_LAST);
    Stall   = mem_op & ~mem_ready & ~abort;
    mem_req = mem_op & ~abort;
  end

  // Writeback data select; an abandoned load returns the error pattern
  always_comb begin
    case (m2r_q)
      2'b01:   wb_data_d = abort ? ERR_DATA : mem_rdata;
      2'b10:   wb_data_d = pc4_q;
      default: wb_data_d = alu_q;
    endcase
  end

  // MEM/WB register: bubble (write-enable only) while stalled, capture otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_wb_q   <= 1'b0;
      rd_wb_q   <= '0;
      wb_data_q <= '0;
    end else if (Stall) begin
      rw_wb_q <= 1'b0;
    end else begin
      rw_wb_q   <= RegWrite_mem;
      rd_wb_q   <= rd_q;
      wb_data_q <= wb_data_d;
    end
  end

  assign mem_we           = mwr_q;
  assign mem_addr         = alu_q;
  assign mem_wdata        = wdata_q;
  assign ALUResult_mem    = alu_q;
  assign RegWrite_mem     = rw_q & (rd_q != 5'd0);
  assign RegWriteAddr_mem = rd_q;
  assign RegWrite_wb      = rw_wb_q;
  assign RegWriteAddr_wb  = rd_wb_q;
  assign RegWriteData     = wb_data_q;
  assign MemErr           = err_q;

endmodule
